// File: rtl/a_operand_feeder.sv
// a_operand_feeder: streams K packed A-words from buffer A and emits them as a
// diagonally skewed 4-lane byte stream (lane r delayed r cycles, zero padded)
// for the left edge of the systolic array.

// One lane: DEPTH delay stages followed by the output register.
// Lane 0 (DEPTH=0) is just the output register.
module a_lane #(
  parameter int W     = 8,
  parameter int DEPTH = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [DEPTH:0][W-1:0] sh;

  // shift the lane byte one stage per cycle; reset clears the whole line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh <= '0;
    end else begin
      sh[0] <= d;
      for (int i = 1; i <= DEPTH; i++) sh[i] <= sh[i-1];
    end
  end

  assign q = sh[DEPTH];
endmodule

module a_operand_feeder #(
  parameter int DATA_SIZE = 8,
  parameter int WORD_SIZE = 32,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_SIZE-1:0] base_index,
  input  logic [3:0]           k_len,
  input  logic [2:0]           rows,
  output logic                 wr_en_a,
  output logic [ADDR_SIZE-1:0] index_a,
  input  logic [WORD_SIZE-1:0] data_in_a,
  output logic [WORD_SIZE-1:0] left_out,
  output logic                 left_valid,
  output logic                 busy,
  output logic                 done
);
  localparam int NUM_LANES = WORD_SIZE / DATA_SIZE;
  localparam int STAGES    = NUM_LANES - 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FIN} state_t;

  state_t               state, state_nxt;
  logic [3:0]           cnt;
  logic [3:0]           k_q;
  logic [NUM_LANES-1:0] lane_en, lane_en_nxt;
  logic [3:0]           rows_eff;
  logic [STAGES:0]      vld_pipe;   // [0]: data_in_a holds a fetched word this cycle
  logic                 accept;

  logic [NUM_LANES-1:0][DATA_SIZE-1:0] lane_d, lane_q;

  assign accept  = (state == IDLE) && start;
  assign wr_en_a = 1'b0;
  assign busy    = (state == FETCH) || (state == DRAIN);
  assign done    = (state == FIN);

  // rows=0 means all lanes; lanes at or above rows are forced to zero
  always_comb begin
    rows_eff    = (rows == 3'd0) ? 4'd4 : {1'b0, rows};
    lane_en_nxt = '0;
    for (int i = 0; i < NUM_LANES; i++) lane_en_nxt[i] = (i < int'(rows_eff));
  end

  // next-state: FETCH for K cycles, DRAIN until the last skewed beat is out
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (k_len == 4'd0) ? FIN : FETCH;
      FETCH:   if (cnt == k_q - 4'd1) state_nxt = DRAIN;
      DRAIN:   if (cnt == 4'(NUM_LANES)) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // state register, per-state cycle counter and accept-time latches
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      k_q     <= '0;
      lane_en <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt != state) ? 4'd0 : cnt + 4'd1;
      if (accept) begin
        k_q     <= k_len;
        lane_en <= lane_en_nxt;
      end
    end
  end

  // read address: base on accept, advance while more words remain, then hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                     index_a <= '0;
    else if (accept && k_len != 4'd0)             index_a <= base_index;
    else if (state == FETCH && state_nxt == FETCH) index_a <= index_a + ADDR_SIZE'(1);
  end

  // read-data valid tracking; a beat leaves the skew while any lane still holds data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe   <= '0;
      left_valid <= 1'b0;
    end else begin
      vld_pipe   <= {vld_pipe[STAGES-1:0], (state == FETCH)};
      left_valid <= |vld_pipe;
    end
  end

  // lane r takes byte (NUM_LANES-1-r) of the word; lane 0 sits in the top byte
  for (genvar r = 0; r < NUM_LANES; r++) begin : g_lane
    assign lane_d[r] = (vld_pipe[0] && lane_en[r]) ?
                       data_in_a[WORD_SIZE-1-r*DATA_SIZE -: DATA_SIZE] : '0;

    a_lane #(.W(DATA_SIZE), .DEPTH(r)) u_lane (
      .clk (clk),
      .rst (rst),
      .d   (lane_d[r]),
      .q   (lane_q[r])
    );

    assign left_out[WORD_SIZE-1-r*DATA_SIZE -: DATA_SIZE] = lane_q[r];
  end
endmodule

// File: tb/tb_a_operand_feeder.sv
// Directed bench for a_operand_feeder: table of transfers with hand-computed
// beats, plus wrap, K=0/K=15, start-while-busy and mid-transfer reset sequences.
module tb_a_operand_feeder;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  base_index;
  logic [3:0]  k_len;
  logic [2:0]  rows;
  logic        wr_en_a;
  logic [7:0]  index_a;
  logic [31:0] data_in_a;
  logic [31:0] left_out;
  logic        left_valid;
  logic        busy;
  logic        done;

  logic [31:0] mem [0:255];
  logic [31:0] exp_beat [0:17];
  logic [7:0]  last_ix;
  int          n_cmp = 0;
  int          n_err = 0;

  typedef struct {
    logic [7:0]       base;
    logic [3:0]       k;
    logic [2:0]       rows;
    logic [5:0][31:0] beats;   // beats[j] = beat j
  } vec_t;
  vec_t tbl [5];

  a_operand_feeder dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_index (base_index),
    .k_len      (k_len),
    .rows       (rows),
    .wr_en_a    (wr_en_a),
    .index_a    (index_a),
    .data_in_a  (data_in_a),
    .left_out   (left_out),
    .left_valid (left_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // buffer A: registered read, data the cycle after the index
  always @(posedge clk) data_in_a <= mem[index_a];

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc %0d: got %h want %h", nm, c, act, exp);
    end
  endtask

  function automatic logic [31:0] beat_of(input logic [7:0] b, input int k, input int rw, input int j);
    logic [31:0] res, w;
    int re;
    res = '0;
    re  = (rw == 0) ? 4 : rw;
    for (int r = 0; r < 4; r++) begin
      if (r < re && j - r >= 0 && j - r < k) begin
        w = mem[8'(int'(b) + j - r)];
        res[31-8*r -: 8] = w[31-8*r -: 8];
      end
    end
    return res;
  endfunction

  task automatic fill_model(input logic [7:0] b, input int k, input int rw);
    for (int j = 0; j < 18; j++) exp_beat[j] = beat_of(b, k, rw, j);
  endtask

  // one transfer from the start cycle (cycle 0) through the IDLE cycle after done
  task automatic do_run(input logic [7:0] b, input int k, input logic [2:0] rw, input bit poke);
    int  dcyc;
    logic exp_lv;
    logic [7:0] exp_ix;
    dcyc = (k == 0) ? 1 : k + 6;
    @(posedge clk); #1;
    start = 1'b1; base_index = b; k_len = 4'(k); rows = rw;
    for (int c = 1; c <= dcyc + 1; c++) begin
      @(posedge clk); #1;
      start = poke && (c == 2 || c == k + 6);
      if (start) begin base_index = 8'h40; k_len = 4'd7; rows = 3'd1; end
      @(negedge clk);
      exp_lv = (k != 0) && c >= 3 && c <= k + 5;
      if (k == 0)     exp_ix = last_ix;
      else if (c <= k) exp_ix = 8'(int'(b) + c - 1);
      else             exp_ix = 8'(int'(b) + k - 1);
      chk("left_valid", c, {31'b0, left_valid}, {31'b0, exp_lv});
      chk("left_out",   c, left_out, exp_lv ? exp_beat[c-3] : 32'h0);
      chk("busy",       c, {31'b0, busy}, {31'b0, (k != 0 && c <= k + 5)});
      chk("done",       c, {31'b0, done}, {31'b0, (c == dcyc)});
      chk("index_a",    c, {24'b0, index_a}, {24'b0, exp_ix});
      chk("wr_en_a",    c, {31'b0, wr_en_a}, 32'h0);
    end
    start = 1'b0;
    if (k != 0) last_ix = 8'(int'(b) + k - 1);
  endtask

  task automatic load_tbl(input int i);
    for (int j = 0; j < 18; j++) exp_beat[j] = (j < 6) ? tbl[i].beats[j] : 32'h0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD0000 | 32'(i);
    mem[8]    = 32'h01020304; mem[9]    = 32'h05060708; mem[10] = 32'h090A0B0C;
    mem[11]   = 32'h11121314; mem[12]   = 32'h15161718;
    mem[8'hFE] = 32'h11223344; mem[8'hFF] = 32'h55667788;
    mem[8'h00] = 32'h99AABBCC; mem[8'h01] = 32'hDDEEFF00;
    for (int i = 0; i < 15; i++) mem[8'h20 + i] = 32'h10203040 + 32'h01010101 * 32'(i);

    tbl[0] = '{8'd8, 4'd3, 3'd4, {32'h0000000C, 32'h00000B08, 32'h000A0704,
                                  32'h09060300, 32'h05020000, 32'h01000000}};
    tbl[1] = '{8'd8, 4'd3, 3'd2, {32'h00000000, 32'h00000000, 32'h000A0000,
                                  32'h09060000, 32'h05020000, 32'h01000000}};
    tbl[2] = '{8'd8, 4'd3, 3'd1, {32'h00000000, 32'h00000000, 32'h00000000,
                                  32'h09000000, 32'h05000000, 32'h01000000}};
    tbl[3] = '{8'd8, 4'd3, 3'd0, {32'h0000000C, 32'h00000B08, 32'h000A0704,
                                  32'h09060300, 32'h05020000, 32'h01000000}};
    tbl[4] = '{8'd9, 4'd1, 3'd3, {32'h00000000, 32'h00000000, 32'h00000000,
                                  32'h00000700, 32'h00060000, 32'h05000000}};

    rst = 1'b0; start = 1'b0; base_index = '0; k_len = '0; rows = '0;
    last_ix = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst left_out",   0, left_out, 32'h0);
    chk("rst left_valid", 0, {31'b0, left_valid}, 32'h0);
    chk("rst busy",       0, {31'b0, busy}, 32'h0);
    chk("rst done",       0, {31'b0, done}, 32'h0);
    chk("rst index_a",    0, {24'b0, index_a}, 32'h0);
    rst = 1'b1;

    // table-driven transfers
    for (int i = 0; i < 5; i++) begin
      load_tbl(i);
      do_run(tbl[i].base, int'(tbl[i].k), tbl[i].rows, 1'b0);
    end

    // address wrap
    fill_model(8'hFE, 4, 4);
    do_run(8'hFE, 4, 3'd4, 1'b0);

    // K=0: done in cycle 1, no beats, index untouched
    fill_model(8'h30, 0, 4);
    do_run(8'h30, 0, 3'd4, 1'b0);

    // K=15: 18 contiguous beats, index ends at base+14
    fill_model(8'h20, 15, 4);
    do_run(8'h20, 15, 3'd4, 1'b0);

    // start pulses during FETCH and FIN are ignored; next run follows
    load_tbl(0);
    do_run(8'd8, 3, 3'd4, 1'b1);
    load_tbl(1);
    do_run(8'd8, 3, 3'd2, 1'b0);

    // reset in cycle 4 of a K=5 run
    @(posedge clk); #1;
    start = 1'b1; base_index = 8'd8; k_len = 4'd5; rows = 3'd4;
    for (int c = 1; c <= 3; c++) begin @(posedge clk); #1; start = 1'b0; end
    @(negedge clk);
    chk("pre-rst left_valid", 3, {31'b0, left_valid}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst left_out",   4, left_out, 32'h0);
    chk("midrst left_valid", 4, {31'b0, left_valid}, 32'h0);
    chk("midrst busy",       4, {31'b0, busy}, 32'h0);
    chk("midrst done",       4, {31'b0, done}, 32'h0);
    chk("midrst index_a",    4, {24'b0, index_a}, 32'h0);
    chk("midrst wr_en_a",    4, {31'b0, wr_en_a}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    last_ix = 8'h00;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("post-rst left_valid", c, {31'b0, left_valid}, 32'h0);
      chk("post-rst left_out",   c, left_out, 32'h0);
    end
    mem[0] = 32'hAABBCCDD;
    for (int j = 0; j < 18; j++) exp_beat[j] = 32'h0;
    exp_beat[0] = 32'hAA000000; exp_beat[1] = 32'h00BB0000;
    exp_beat[2] = 32'h0000CC00; exp_beat[3] = 32'h000000DD;
    do_run(8'h00, 1, 3'd4, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
